dma_apb_cfg_master: RTL and testbench

//  APB requester that programs the DMA engine's register file and collects its completion.
//  - Accepts one transfer descriptor (src, dst, size) per valid/ready handshake.
//  - Issues APB writes to SRC, DEST, SIZE and MODE(=1), then waits for INTR.
//  - Writes INT to clear the DMA, then returns a status word to the requester.
//  - Sits between the test/CPU-side sequencer and the DMA's APB slave port.

---
 rtl/dma_pkg.sv | 35 +++
 rtl/apb_write_port.sv | 60 ++++++
 rtl/dma_apb_cfg_master.sv | 149 ++++++++++++++
 tb/tb_dma_apb_cfg_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// DMA register map, completion status codes and the
// state encodings used by the APB configuration master.
package dma_pkg;

   localparam logic [7:0] DMA_SRC_OFS  = 8'h00;
   localparam logic [7:0] DMA_DST_OFS  = 8'h04;
   localparam logic [7:0] DMA_SIZE_OFS = 8'h08;
   localparam logic [7:0] DMA_MODE_OFS = 8'h0C;
   localparam logic [7:0] DMA_INT_OFS  = 8'h10;

   typedef enum logic [1:0] {
      DMA_OK       = 2'd0,
      DMA_TIMEOUT  = 2'd1,
      DMA_ERR_SIZE = 2'd2
   } dma_status_e;

   // SETUP/ACCESS live in apb_write_port; XFER covers both here
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_XFER   = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   function automatic logic [7:0] dma_reg_ofs(input logic [2:0] idx);
      logic [7:0] ofs;
      case (idx)
         3'd0:    ofs = DMA_SRC_OFS;
         3'd1:    ofs = DMA_DST_OFS;
         3'd2:    ofs = DMA_SIZE_OFS;
         3'd3:    ofs = DMA_MODE_OFS;
         default: ofs = DMA_INT_OFS;
      endcase
      return ofs;
   endfunction

endpackage

// File: rtl/apb_write_port.sv
// Single APB write: SETUP then ACCESS until PREADY or timeout.
// addr/data are held stable by the caller for the whole write.
module apb_write_port #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  done,
   output logic                  timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic        psel_q;
   logic        pen_q;
   logic [15:0] timer_q;
   logic        access;

   assign access  = psel_q & pen_q;
   assign done    = access & PREADY;
   assign timeout = access & ~PREADY & (timer_q >= TO_LAST);

   assign PSEL    = psel_q;
   assign PENABLE = pen_q;
   assign PWRITE  = psel_q;
   assign PADDR   = psel_q ? addr : '0;
   assign PWDATA  = psel_q ? data : '0;

   // start wins over done so back-to-back writes need no idle cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         psel_q  <= 1'b0;
         pen_q   <= 1'b0;
         timer_q <= '0;
      end else if (start) begin
         psel_q <= 1'b1;
         pen_q  <= 1'b0;
      end else if (psel_q & ~pen_q) begin
         pen_q   <= 1'b1;
         timer_q <= '0;
      end else if (done | timeout) begin
         psel_q <= 1'b0;
         pen_q  <= 1'b0;
      end else if (access && timer_q != 16'hFFFF) begin
         timer_q <= timer_q + 16'd1;
      end
   end

endmodule

// File: rtl/dma_apb_cfg_master.sv
// Programs the DMA over APB from one descriptor, waits for INTR,
// clears it and reports a status word back to the requester.
module dma_apb_cfg_master
   import dma_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    TIMEOUT_CYCLES = 65535
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  desc_valid,
   output logic                  desc_ready,
   input  logic [DATA_WIDTH-1:0] desc_src,
   input  logic [DATA_WIDTH-1:0] desc_dst,
   input  logic [DATA_WIDTH-1:0] desc_size,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic [1:0]            done_status,
   output logic                  busy,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic                  INTR
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]            state_q;
   logic [2:0]            idx_q;
   logic [DATA_WIDTH-1:0] src_q;
   logic [DATA_WIDTH-1:0] dst_q;
   logic [DATA_WIDTH-1:0] size_q;
   dma_status_e           status_q;
   logic [15:0]           timer_q;

   logic                  accept;
   logic                  intr_to;
   logic                  wr_start;
   logic                  wr_done;
   logic                  wr_timeout;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   assign desc_ready  = (state_q == ST_IDLE);
   assign busy        = ~desc_ready;
   assign done_valid  = (state_q == ST_REPORT);
   assign done_status = status_q;

   assign accept  = desc_ready & desc_valid;
   assign intr_to = (timer_q >= TO_LAST);

   assign wr_start =
      (accept & (desc_size != '0)) |
      ((state_q == ST_XFER) & wr_done & (idx_q < 3'd3)) |
      ((state_q == ST_WAIT) & (INTR | intr_to));

   assign wr_addr = BASE_ADDR + ADDR_WIDTH'(dma_reg_ofs(idx_q));

   always_comb begin
      wr_data = DATA_WIDTH'(1);
      case (idx_q)
         3'd0:    wr_data = src_q;
         3'd1:    wr_data = dst_q;
         3'd2:    wr_data = size_q;
         default: wr_data = DATA_WIDTH'(1);
      endcase
   end

   apb_write_port #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wr (
      .CLK     (CLK),
      .RST     (RST),
      .start   (wr_start),
      .addr    (wr_addr),
      .data    (wr_data),
      .done    (wr_done),
      .timeout (wr_timeout),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PREADY  (PREADY)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         size_q   <= '0;
         status_q <= DMA_OK;
         timer_q  <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (desc_valid) begin
               src_q  <= desc_src;
               dst_q  <= desc_dst;
               size_q <= desc_size;
               if (desc_size == '0) begin
                  status_q <= DMA_ERR_SIZE;
                  state_q  <= ST_REPORT;
               end else begin
                  status_q <= DMA_OK;
                  idx_q    <= '0;
                  state_q  <= ST_XFER;
               end
            end
            ST_XFER: if (wr_timeout) begin
               status_q <= DMA_TIMEOUT;
               state_q  <= ST_REPORT;
            end else if (wr_done) begin
               if (idx_q < 3'd3) begin
                  idx_q <= idx_q + 3'd1;
               end else if (idx_q == 3'd3) begin
                  timer_q <= '0;
                  state_q <= ST_WAIT;
               end else begin
                  state_q <= ST_REPORT;
               end
            end
            // a missing INTR still gets the INT write to clear the DMA
            ST_WAIT: if (INTR) begin
               idx_q   <= 3'd4;
               state_q <= ST_XFER;
            end else if (intr_to) begin
               status_q <= DMA_TIMEOUT;
               idx_q    <= 3'd4;
               state_q  <= ST_XFER;
            end else if (timer_q != 16'hFFFF) begin
               timer_q <= timer_q + 16'd1;
            end
            ST_REPORT: if (done_ready) begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_apb_cfg_master.sv
// Timeline-model bench: each descriptor is expanded into expected
// per-cycle outputs and the stimulus that drives it.
module tb_dma_apb_cfg_master;

   localparam int          TO   = 16;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int          MAXC = 8192;

   logic        CLK = 1'b0;
   logic        RST;
   logic        desc_valid;
   logic        desc_ready;
   logic [31:0] desc_src;
   logic [31:0] desc_dst;
   logic [31:0] desc_size;
   logic        done_valid;
   logic        done_ready;
   logic [1:0]  done_status;
   logic        busy;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PREADY;
   logic        INTR;

   always #5 CLK = ~CLK;

   dma_apb_cfg_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .BASE_ADDR      (BASE),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .desc_valid  (desc_valid),
      .desc_ready  (desc_ready),
      .desc_src    (desc_src),
      .desc_dst    (desc_dst),
      .desc_size   (desc_size),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .done_status (done_status),
      .busy        (busy),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PREADY      (PREADY),
      .INTR        (INTR)
   );

   bit          e_chk[MAXC];
   bit          e_strict[MAXC];
   bit          e_psel[MAXC];
   bit          e_pen[MAXC];
   bit          e_dv[MAXC];
   bit          e_busy[MAXC];
   bit          e_dr[MAXC];
   logic [31:0] e_addr[MAXC];
   logic [31:0] e_data[MAXC];
   logic [1:0]  e_st[MAXC];

   bit          d_rst[MAXC];
   bit          d_dv[MAXC];
   bit          d_pr[MAXC];
   bit          d_in[MAXC];
   bit          d_dr[MAXC];
   logic [31:0] d_src[MAXC];
   logic [31:0] d_dst[MAXC];
   logic [31:0] d_sz[MAXC];

   int t = 0;
   int t_end = 2;
   int cyc = 0;
   int n_done_exp = 0;
   int n_wr_exp = 0;
   bit hold_dv = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] obs_wr[$];
   logic [1:0]  obs_st[$];

   task automatic put(input bit ps, input bit pe,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit dv, input logic [1:0] st,
                      input bit bz);
      e_chk[t]  = 1'b1;
      e_psel[t] = ps;
      e_pen[t]  = pe;
      e_addr[t] = a;
      e_data[t] = d;
      e_dv[t]   = dv;
      e_st[t]   = st;
      e_busy[t] = bz;
      e_dr[t]   = ~bz;
      if (bz) d_dv[t] = hold_dv | 1'($urandom % 2);
      t++;
   endtask

   task automatic fill_idle(input int n);
      for (int i = 0; i < n; i++) begin
         d_dv[t] = 1'b0;
         put(0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   // wK: PREADY-low cycles in each ACCESS; idly: WAIT cycles before INTR;
   // ddly: REPORT cycles before done_ready; rstk: write index to reset in
   task automatic txn(input logic [31:0] src, input logic [31:0] dst,
                      input logic [31:0] size,
                      input int w0, input int w1, input int w2,
                      input int w3, input int w4,
                      input int idly, input int ddly, input int rstk,
                      input bit hold);
      int          w[5];
      logic [31:0] dat[5];
      logic [31:0] ad;
      logic [1:0]  st;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
      dat[0] = src; dat[1] = dst; dat[2] = size;
      dat[3] = 32'd1; dat[4] = 32'd1;
      hold_dv = hold;
      d_dv[t]  = 1'b1;
      d_src[t] = src;
      d_dst[t] = dst;
      d_sz[t]  = size;
      put(0, 0, 0, 0, 0, 0, 0);
      st = (size == 0) ? 2'd2 : 2'd0;
      for (int k = 0; k < 5 && size != 0; k++) begin
         ad = BASE + 32'(4 * k);
         if (k == 4) begin
            if (idly < TO) begin
               for (int i = 0; i < idly; i++) begin
                  d_in[t] = 1'b0;
                  put(0, 0, 0, 0, 0, 0, 1);
               end
               d_in[t] = 1'b1;
               put(0, 0, 0, 0, 0, 0, 1);
            end else begin
               for (int i = 0; i < TO; i++) begin
                  d_in[t] = 1'b0;
                  put(0, 0, 0, 0, 0, 0, 1);
               end
               st = 2'd1;
            end
         end
         put(1, 0, ad, dat[k], 0, 0, 1);
         if (rstk == k) begin
            d_rst[t] = 1'b1;
            d_pr[t]  = 1'b0;
            put(1, 1, ad, dat[k], 0, 0, 1);
            d_dv[t]     = 1'b0;
            e_strict[t] = 1'b1;
            put(0, 0, 0, 0, 0, 0, 0);
            return;
         end
         if (w[k] >= TO) begin
            for (int i = 0; i < TO; i++) begin
               d_pr[t] = 1'b0;
               put(1, 1, ad, dat[k], 0, 0, 1);
            end
            st = 2'd1;
            break;
         end
         for (int i = 0; i < w[k]; i++) begin
            d_pr[t] = 1'b0;
            put(1, 1, ad, dat[k], 0, 0, 1);
         end
         d_pr[t] = 1'b1;
         put(1, 1, ad, dat[k], 0, 0, 1);
         n_wr_exp++;
      end
      for (int i = 0; i <= ddly; i++) begin
         d_dr[t] = (i == ddly);
         put(0, 0, 0, 0, 1, st, 1);
      end
      n_done_exp++;
   endtask

   task automatic apply(input int n);
      RST        = d_rst[n];
      desc_valid = d_dv[n];
      desc_src   = d_src[n];
      desc_dst   = d_dst[n];
      desc_size  = d_sz[n];
      PREADY     = d_pr[n];
      INTR       = d_in[n];
      done_ready = d_dr[n];
   endtask

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   initial begin : drive
      for (int c = 0; c < MAXC; c++) begin
         d_pr[c]  = 1'($urandom % 2);
         d_in[c]  = 1'($urandom % 2);
         d_dr[c]  = 1'($urandom % 2);
         d_src[c] = $urandom;
         d_dst[c] = $urandom;
         d_sz[c]  = $urandom;
      end
      d_rst[0] = 1'b1;
      t = 1;
      d_rst[1] = 1'b1;
      e_strict[1] = 1'b1;
      e_strict[2] = 1'b1;
      fill_idle(2);

      txn(32'h0010_0000, 32'h104, 32'd12, 1,1,1,1,1, 12, 0, -1, 0);
      fill_idle(1);
      txn(32'h0010_0000, 32'h104, 32'd12, 3,3,3,3,3, 5, 1, -1, 0);
      txn(32'h1, 32'h2, 32'd0, 0,0,0,0,0, 0, 1, -1, 0);
      fill_idle(2);
      txn(32'hA0, 32'hB0, 32'd64, 0,0,0,0,0, 100, 0, -1, 0);
      txn(32'h11, 32'h22, 32'd33, 0,2,1,0,2, 3, 10, -1, 1);
      fill_idle(1);
      txn(32'h55, 32'h66, 32'd77, 0,0,0,0,0, 3, 0, 2, 0);
      txn(32'hCAFE_0000, 32'h8, 32'h40, 0,0,0,0,0, 4, 0, -1, 0);
      txn(32'h100, 32'h200, 32'd4, 0,0,0,0,0, 15, 0, -1, 0);
      txn(32'h300, 32'h400, 32'd8, 15,0,0,0,0, 2, 0, -1, 0);
      txn(32'h500, 32'h600, 32'd8, 16,0,0,0,0, 2, 0, -1, 0);

      for (int n = 0; n < 30 && t < MAXC - 300; n++) begin
         int wr[5];
         int idly;
         int rk;
         logic [31:0] sz;
         for (int j = 0; j < 5; j++)
            wr[j] = ($urandom % 10 == 0) ? 16 + int'($urandom % 3)
                                         : int'($urandom % 4);
         idly = ($urandom % 5 == 0) ? 16 + int'($urandom % 4)
                                    : int'($urandom % 16);
         rk = ($urandom % 10 == 0) ? int'($urandom % 5) : -1;
         sz = ($urandom % 6 == 0) ? 32'd0 : $urandom;
         txn($urandom, $urandom, sz, wr[0], wr[1], wr[2], wr[3], wr[4],
             idly, int'($urandom % 4), rk, 1'($urandom % 2));
         fill_idle(int'($urandom % 3));
      end
      fill_idle(3);
      t_end = t;

      apply(0);
      for (int n = 1; n < t_end; n++) begin
         @(posedge CLK);
         #1;
         cyc = n;
         apply(n);
      end
   end

   initial begin : compare
      bit          fin;
      bit          ok;
      int          c;
      logic [63:0] t1[5];
      logic [1:0]  sts[9];
      t1[0] = {BASE + 32'h00, 32'h0010_0000};
      t1[1] = {BASE + 32'h04, 32'h0000_0104};
      t1[2] = {BASE + 32'h08, 32'd12};
      t1[3] = {BASE + 32'h0C, 32'd1};
      t1[4] = {BASE + 32'h10, 32'd1};
      sts = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      fin = 1'b0;
      while (!fin) begin
         @(negedge CLK);
         c = cyc;
         if (e_chk[c]) begin
            ok = (PSEL === e_psel[c]) && (PENABLE === e_pen[c]) &&
                 (done_valid === e_dv[c]) && (busy === e_busy[c]) &&
                 (desc_ready === e_dr[c]);
            if (e_psel[c])
               ok = ok && (PWRITE === 1'b1) && (PADDR === e_addr[c]) &&
                    (PWDATA === e_data[c]);
            if (e_dv[c])
               ok = ok && (done_status === e_st[c]);
            if (e_strict[c])
               ok = ok && (PWRITE === 1'b0) && (PADDR === 32'h0) &&
                    (PWDATA === 32'h0) && (done_status === 2'd0);
            n_cmp++;
            if (!ok) begin
               n_err++;
               $display("FAIL cycle %0d: got sel/en/wr=%b%b%b a=%h d=%h dv=%b st=%0d busy=%b rdy=%b want sel/en=%b%b a=%h d=%h dv=%b st=%0d busy=%b rdy=%b",
                        c, PSEL, PENABLE, PWRITE, PADDR, PWDATA, done_valid,
                        done_status, busy, desc_ready, e_psel[c], e_pen[c],
                        e_addr[c], e_data[c], e_dv[c], e_st[c], e_busy[c],
                        e_dr[c]);
            end
         end
         if (PSEL === 1'b1 && PENABLE === 1'b1 && PREADY === 1'b1)
            obs_wr.push_back({PADDR, PWDATA});
         if (done_valid === 1'b1 && done_ready === 1'b1)
            obs_st.push_back(done_status);
         if (c >= t_end - 1) fin = 1'b1;
      end

      chk("write_count", 64'(obs_wr.size()), 64'(n_wr_exp));
      chk("done_count", 64'(obs_st.size()), 64'(n_done_exp));
      if (obs_wr.size() >= 23) begin
         for (int k = 0; k < 5; k++)
            chk($sformatf("t1_write%0d", k), obs_wr[k], t1[k]);
         chk("after_reset_src", obs_wr[22], {BASE, 32'hCAFE_0000});
      end
      if (obs_st.size() >= 9) begin
         for (int k = 0; k < 9; k++)
            chk($sformatf("directed_status%0d", k),
                64'(obs_st[k]), 64'(sts[k]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
